// File: rtl/fan_tick_gen.sv
// fan_tick_gen
// Turns a once-per-revolution hall sensor into TICKS evenly spaced degree
// ticks per revolution. The revolution period is measured between accepted
// hall edges and is then divided into TICKS parts by a phase accumulator.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   hall   in   raw hall sensor, asynchronous to clk
//   fanclk out  one-cycle degree tick
//   index  out  one-cycle revolution-start pulse
//   locked out  high while ticks are being generated (RUN)
//   period out  last measured revolution period, clk cycles
//
// state   | meaning
// IDLE    | no revolution reference, waiting for any hall edge
// MEASURE | one edge seen, timing the first full revolution
// RUN     | period known, generating index and degree ticks
module fan_tick_gen #(
  parameter int TICKS      = 360,
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 1000,
  parameter int MAX_PERIOD = (1 << 20) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hall,
  output logic             fanclk,
  output logic             index,
  output logic             locked,
  output logic [CNT_W-1:0] period
);

  localparam int TC_W = $clog2(TICKS + 1);

  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   TICKS_A = (CNT_W + 1)'(TICKS);
  localparam logic [TC_W-1:0]  TICKS_T = TC_W'(TICKS);
  localparam logic [TC_W-1:0]  TC_ONE  = TC_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t state, state_next;

  logic             hall_s1, hall_s2, hall_s3;
  logic             hall_rise, accept, timeout, crossing, tick_room;
  logic             index_next, fanclk_next, period_load;
  logic [CNT_W-1:0] per_cnt, per_cnt_inc;
  logic [CNT_W:0]   acc, acc_sum;
  logic [TC_W-1:0]  tick_cnt;

  // Two synchronizer stages plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hall_s1 <= 1'b0;
      hall_s2 <= 1'b0;
      hall_s3 <= 1'b0;
    end else begin
      hall_s1 <= hall;
      hall_s2 <= hall_s1;
      hall_s3 <= hall_s2;
    end
  end

  assign hall_rise   = hall_s2 & ~hall_s3;
  assign per_cnt_inc = (per_cnt >= MAX_P) ? MAX_P : per_cnt + CNT_ONE;
  assign accept      = hall_rise & ((state == IDLE) | (per_cnt >= MIN_P));
  // Tracking is dropped on the same edge that per_cnt lands on MAX_PERIOD.
  assign timeout     = (state != IDLE) & ~accept & (per_cnt_inc == MAX_P);

  // acc never exceeds period + TICKS, so the extra bit covers the sum.
  assign acc_sum   = acc + TICKS_A;
  assign crossing  = acc_sum >= {1'b0, period};
  assign tick_room = tick_cnt < TICKS_T;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    index_next  = 1'b0;
    period_load = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = MEASURE;
      end
      MEASURE, RUN: begin
        if (accept) begin
          state_next  = RUN;
          index_next  = 1'b1;
          period_load = 1'b1;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // An edge in the same cycle as a crossing restarts the revolution instead.
  assign fanclk_next = (state == RUN) & (state_next == RUN) & ~accept &
                       crossing & tick_room;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt  <= '0;
      acc      <= '0;
      tick_cnt <= '0;
    end else begin
      per_cnt <= accept ? CNT_ONE : per_cnt_inc;
      if (accept) begin
        acc      <= TICKS_A;
        tick_cnt <= '0;
      end else if (state == RUN) begin
        if (crossing) begin
          acc <= acc_sum - {1'b0, period};
          if (tick_room) tick_cnt <= tick_cnt + TC_ONE;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fanclk <= 1'b0;
      index  <= 1'b0;
      locked <= 1'b0;
      period <= '0;
    end else begin
      fanclk <= fanclk_next;
      index  <= index_next;
      locked <= (state_next == RUN);
      if (period_load) period <= per_cnt;
    end
  end

endmodule

// File: doc/fan_tick_gen.md
FAN_TICK_GEN -- requirements
Module: fan_tick_gen

Interface
REQ-001 SHALL have parameter TICKS, default 360, meaning degree ticks per revolution.
REQ-002 SHALL have parameter CNT_W, default 24, meaning width of the period counter and period register.
REQ-003 SHALL have parameter MIN_PERIOD, default 1000, meaning the minimum accepted edge spacing in clk cycles; legal only if MIN_PERIOD >= TICKS.
REQ-004 SHALL have parameter MAX_PERIOD, default 2^20-1, meaning the timeout limit in clk cycles; legal only if MAX_PERIOD < 2^CNT_W.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock.
REQ-006 SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-007 SHALL have port hall, input, 1 bit, the raw once-per-revolution sensor, asynchronous to clk.
REQ-008 SHALL have port fanclk, output, 1 bit, a one-cycle degree-tick pulse consumed by the downstream degree counter.
REQ-009 SHALL have port index, output, 1 bit, a one-cycle revolution-start pulse.
REQ-010 SHALL have port locked, output, 1 bit, high while in state RUN.
REQ-011 SHALL have port period, output, CNT_W bits, the last measured revolution period in clk cycles.

Function
REQ-012 SHALL pass hall through a 2-flop synchronizer, then detect a rising edge on the synchronized signal.
REQ-013 SHALL keep per_cnt, which increments every clk and saturates at MAX_PERIOD; an accepted edge loads per_cnt to 1.
REQ-014 SHALL accept an edge unconditionally in IDLE; in MEASURE or RUN, it SHALL accept an edge only if per_cnt >= MIN_PERIOD, and otherwise ignore it with no state change.
REQ-015 SHALL implement states IDLE, MEASURE and RUN.
REQ-016 SHALL transition IDLE -> MEASURE on an accepted edge, with no index pulse and no period update.
REQ-017 SHALL transition MEASURE -> RUN on an accepted edge, loading period with per_cnt and pulsing index.
REQ-018 SHALL stay in RUN on an accepted edge, loading period with per_cnt and pulsing index.
REQ-019 SHALL transition MEASURE or RUN -> IDLE when per_cnt reaches MAX_PERIOD with no accepted edge in that cycle; period SHALL hold its last value.
REQ-020 SHALL give an accepted edge priority over timeout in the same cycle.
REQ-021 SHALL keep an accumulator acc of CNT_W+1 bits.
REQ-022 SHALL load acc with TICKS and clear tick_cnt on an accepted edge.
REQ-023 SHALL, in RUN cycles with no accepted edge, set acc to acc+TICKS, or to acc+TICKS-period when acc+TICKS >= period; the latter case is a crossing.
REQ-024 SHALL, on a crossing with tick_cnt < TICKS, increment tick_cnt and assert fanclk for one cycle; crossings with tick_cnt == TICKS SHALL be suppressed.
REQ-025 SHALL, when the same cycle holds an accepted edge and a crossing, let the edge win, so no fanclk is generated from that crossing.
REQ-026 SHALL register fanclk, index and locked; index SHALL be high exactly one cycle, 3 or 4 clk after the hall rise.
REQ-027 SHALL place the n-th fanclk after index cycle e (n = 1..TICKS) at cycle e + ceil(n*P/TICKS) - 1, where P = period; at most one fanclk per cycle.
REQ-028 SHALL hold fanclk and index low outside RUN.

Reset
REQ-029 SHALL, while rst = 0, immediately force state IDLE and set fanclk = 0, index = 0, locked = 0, period = 0, per_cnt = 0, acc = 0, tick_cnt = 0 and the synchronizer flops to 0.
REQ-030 SHALL, after rst deasserts mid-operation, require two accepted edges before locked returns to 1.

Verification
REQ-031 SHALL cover: hall rising every 36000 clk -> after the 2nd edge locked=1 and period=36000; 360 fanclk per revolution, spaced exactly 100 clk; first fanclk at index+99.
REQ-032 SHALL cover: period 36050 -> exactly 360 fanclk per revolution, spacings 100 or 101; the last fanclk falls 1 cycle before the next index.
REQ-033 SHALL cover: a glitch edge 500 clk after an accepted edge -> ignored, with index, period and fanclk spacing unchanged.
REQ-034 SHALL cover: a slowdown from 36000 to 40000 -> for that revolution, 360 fanclk based on the old period and then none until the next index; the next revolution spaces fanclk at 111/112.
REQ-035 SHALL cover: MAX_PERIOD=50000 with hall stopped while in RUN -> locked falls 50000-1 clk after the last index, fanclk stops and period holds 36000.
REQ-036 SHALL cover: rst pulled low mid-revolution -> all outputs 0 asynchronously; after release, the first edge gives no index and the second edge sets locked=1.
